// File: rtl/i2c_req_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_req_arbiter
//
// Shares one I2C master byte transmitter between NUM_REQ requesters. An idle
// arbiter picks the next valid requester in round-robin order, latches its
// byte onto m_data, pulses req_ready to that requester and m_start to the
// master, then holds the byte stable until the master reports m_done. A
// watchdog aborts the transfer if m_done never arrives.
//
// Ports
//   clk          in   1                       system clock, rising edge
//   reset        in   1                       asynchronous, active-low reset
//   req_valid    in   NUM_REQ                 requester i has a byte pending
//   req_data     in   NUM_REQ*MESSAGE_LENGTH  byte of requester i at slice i
//   req_ready    out  NUM_REQ                 one-hot accept pulse (1 cycle)
//   m_data       out  MESSAGE_LENGTH          byte to master data input
//   m_start      out  1                       master start pulse (1 cycle)
//   m_done       in   1                       master finished current byte
//   grant_id     out  $clog2(NUM_REQ)         current/last granted requester
//   busy         out  1                       high whenever not idle
//   timeout_err  out  1                       watchdog abort pulse (1 cycle)
// ----------------------------------------------------------------------------
module i2c_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int MESSAGE_LENGTH = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ*MESSAGE_LENGTH-1:0] req_data,
   output logic [NUM_REQ-1:0]                req_ready,
   output logic [MESSAGE_LENGTH-1:0]         m_data,
   output logic                              m_start,
   input  logic                              m_done,
   output logic [$clog2(NUM_REQ)-1:0]        grant_id,
   output logic                              busy,
   output logic                              timeout_err
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT
   } state_e;

   state_e                    state_q, state_d;
   logic [IDW-1:0]            last_q, last_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [MESSAGE_LENGTH-1:0] m_data_q, m_data_d;
   logic [IDW-1:0]            grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0]        req_ready_q, req_ready_d;
   logic                      m_start_q, m_start_d;
   logic                      busy_q, busy_d;
   logic                      timeout_err_q, timeout_err_d;

   logic                      any_valid;
   logic [IDW-1:0]            win_id;
   logic [MESSAGE_LENGTH-1:0] win_data;

   // Round-robin pick: scan last+NUM_REQ down to last+1 so that the closest
   // valid requester after 'last' overwrites any farther one.
   function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [IDW-1:0]     last);
      logic [IDW-1:0] w;
      logic [IDW-1:0] idx;
      w = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IDW'((int'(last) + k) % NUM_REQ);
         if (v[idx]) w = idx;
      end
      return w;
   endfunction

   always_comb begin
      any_valid = |req_valid;
      win_id    = rr_pick(req_valid, last_q);
      win_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDW'(i) == win_id) win_data = req_data[i*MESSAGE_LENGTH +: MESSAGE_LENGTH];
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      // NOTE: every signal gets its default before the case statement, so no
      // path through this block leaves a value unassigned (no latches).
      state_d       = state_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      m_data_d      = m_data_q;
      grant_id_d    = grant_id_q;
      req_ready_d   = '0;
      m_start_d     = 1'b0;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               m_data_d    = win_data;
               grant_id_d  = win_id;
               req_ready_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
               m_start_d   = 1'b1;
               last_d      = win_id;
               state_d     = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Done takes priority over a coincident terminal count.
            if (m_done) begin
               state_d = ST_IDLE;
            end else if (cnt_q == TERM_CNT) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values computed above.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         last_q        <= IDW'(NUM_REQ - 1);
         cnt_q         <= '0;
         m_data_q      <= '0;
         grant_id_q    <= '0;
         req_ready_q   <= '0;
         m_start_q     <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         cnt_q         <= cnt_d;
         m_data_q      <= m_data_d;
         grant_id_q    <= grant_id_d;
         req_ready_q   <= req_ready_d;
         m_start_q     <= m_start_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign m_data      = m_data_q;
   assign m_start     = m_start_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_i2c_req_arbiter
//
// Directed bench for i2c_req_arbiter (NUM_REQ=4, 8-bit bytes, 64-cycle
// watchdog). Inputs are driven and outputs sampled 1 ns after the rising
// edge; expected values are written out by hand.
// ----------------------------------------------------------------------------
module tb_i2c_req_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  m_data;
   logic        m_start;
   logic        m_done;
   logic [1:0]  grant_id;
   logic        busy;
   logic        timeout_err;

   int n_checks = 0;
   int n_pass   = 0;

   i2c_req_arbiter #(
      .NUM_REQ       (4),
      .MESSAGE_LENGTH(8),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .m_data     (m_data),
      .m_start    (m_start),
      .m_done     (m_done),
      .grant_id   (grant_id),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (m_start !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_start"}, 32'(m_start), 32'd1);
   endtask

   // Serve one transfer: expect grant exp_id with byte exp_data, switch the
   // valids to next_valid after the ready pulse, answer m_done done_delay
   // cycles after the start cycle, then expect idle.
   task automatic serve(input string tag, input int exp_id, input logic [7:0] exp_data,
                        input logic [3:0] next_valid, input int done_delay);
      wait_start(tag);
      check({tag, "_id"},    32'(grant_id),  32'(exp_id));
      check({tag, "_data"},  32'(m_data),    32'(exp_data));
      check({tag, "_ready"}, 32'(req_ready), 32'd1 << exp_id);
      req_valid = next_valid;
      repeat (done_delay) tick();
      check({tag, "_hold"},  32'(m_data),    32'(exp_data));
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check({tag, "_idle"},  32'(busy),      32'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_m_start"},   32'(m_start),     32'd0);
      check({tag, "_req_ready"}, 32'(req_ready),   32'd0);
      check({tag, "_busy"},      32'(busy),        32'd0);
      check({tag, "_m_data"},    32'(m_data),      32'd0);
      check({tag, "_grant_id"},  32'(grant_id),    32'd0);
      check({tag, "_timeout"},   32'(timeout_err), 32'd0);
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      req_valid = '0;
      m_done    = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset     = 1'b0;
      req_valid = '0;
      m_done    = 1'b0;
      req_data  = {8'h0F, 8'hF0, 8'h95, 8'h5F};
      repeat (2) tick();
      check_zero_outputs("rst");
      reset = 1'b1;
      tick();

      // 1: single requester 0; ready/start one cycle after the sampling edge.
      req_valid = 4'b0001;
      tick();
      check("t1_ready",  32'(req_ready), 32'h1);
      check("t1_start",  32'(m_start),   32'd1);
      check("t1_data",   32'(m_data),    32'h5F);
      check("t1_busy",   32'(busy),      32'd1);
      req_valid = 4'b0000;
      tick();
      check("t1_ready_clr", 32'(req_ready), 32'h0);
      check("t1_start_clr", 32'(m_start),   32'd0);
      check("t1_wait_busy", 32'(busy),      32'd1);
      repeat (3) tick();
      check("t1_hold",   32'(m_data),    32'h5F);
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check("t1_idle",   32'(busy),        32'd0);
      check("t1_no_to",  32'(timeout_err), 32'd0);

      // 6a: m_done while idle is ignored.
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check("t6_idle_done_busy",  32'(busy),    32'd0);
      check("t6_idle_done_start", 32'(m_start), 32'd0);

      // 2: all valid from reset -> grants 0,1,2,3,0.
      do_reset();
      req_valid = 4'b1111;
      serve("t2_g0", 0, 8'h5F, 4'b1111, 10);
      serve("t2_g1", 1, 8'h95, 4'b1111, 10);
      serve("t2_g2", 2, 8'hF0, 4'b1111, 10);
      serve("t2_g3", 3, 8'h0F, 4'b1111, 10);
      serve("t2_g4", 0, 8'h5F, 4'b0010, 10);

      // 3: wrap; after grant 1 only 1 and 3 valid -> 3 then 1.
      serve("t3_g1", 1, 8'h95, 4'b1010, 2);
      serve("t3_g3", 3, 8'h0F, 4'b1010, 2);
      serve("t3_g1b", 1, 8'h95, 4'b0100, 2);

      // 4: watchdog. m_start falls one edge after the start cycle, then 64
      // WAIT cycles elapse before timeout_err shows: 65 ticks from start.
      wait_start("t4");
      check("t4_id", 32'(grant_id), 32'd2);
      req_valid = 4'b0001;
      n = 0;
      while (timeout_err !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("t4_latency", 32'(n),    32'd65);
      check("t4_busy",    32'(busy), 32'd0);
      check("t4_data",    32'(m_data), 32'hF0);
      tick();
      check("t4_pulse_clr", 32'(timeout_err), 32'd0);
      serve("t4_next", 0, 8'h5F, 4'b0000, 3);

      // 6b: m_done on the last WAIT cycle (cnt 63) -> done wins.
      req_valid = 4'b0010;
      wait_start("t6b");
      check("t6b_id", 32'(grant_id), 32'd1);
      req_valid = 4'b0000;
      repeat (64) tick();
      check("t6b_still_wait", 32'(busy),        32'd1);
      check("t6b_no_early",   32'(timeout_err), 32'd0);
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check("t6b_idle",  32'(busy),        32'd0);
      check("t6b_no_to", 32'(timeout_err), 32'd0);
      tick();
      check("t6b_no_to_late", 32'(timeout_err), 32'd0);

      // 6c: m_done during LAUNCH is ignored.
      req_valid = 4'b0100;
      wait_start("t6c");
      req_valid = 4'b0000;
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check("t6c_busy_wait", 32'(busy), 32'd1);
      repeat (2) tick();
      check("t6c_busy_hold", 32'(busy), 32'd1);
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      check("t6c_idle", 32'(busy), 32'd0);

      // 5: reset mid-WAIT clears outputs at once; all-valid then grants 0.
      req_valid = 4'b1000;
      wait_start("t5");
      check("t5_id", 32'(grant_id), 32'd3);
      req_valid = 4'b0000;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      check_zero_outputs("t5_rst");
      req_valid = 4'b1111;
      reset = 1'b1;
      tick();
      check("t5_start", 32'(m_start),   32'd1);
      check("t5_gid",   32'(grant_id),  32'd0);
      check("t5_ready", 32'(req_ready), 32'h1);

      // Reset during LAUNCH drops start/ready at once; nothing resumes.
      reset = 1'b0;
      #1;
      check("t5l_start", 32'(m_start),   32'd0);
      check("t5l_ready", 32'(req_ready), 32'h0);
      req_valid = 4'b0000;
      reset = 1'b1;
      tick();
      check("t5l_busy",  32'(busy),    32'd0);
      check("t5l_idle_start", 32'(m_start), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
